riscv_dmem_resp: RTL
====================

Name: riscv_dmem_resp

Overview:
Data-memory responder for the RISC-V pipelined core. It takes the core's memory-stage request: address from the ALU result, unshifted rs2 store data, and access size from funct3[1:0]. It places store bytes into the correct lanes of a word-organised memory, returns the full 32-bit read word for the core's load decoder, and inserts configurable wait states with a stall signal to the hazard unit.

Parameters:
MP_DATA_WIDTH, 32, data word width; fixed at 32, four byte lanes
MP_ADDR_WIDTH, 32, byte address width from core
MP_DEPTH_LOG2, 10, log2 of memory depth in words
MP_WAIT_CYCLES, 0, extra access latency; 0 selects the combinational-read, single-cycle mode
MP_ENDIANESS, 1, byte-lane order: 1 = big-endian (`RISCV_BIG_ENDIAN), 0 = little-endian

Ports:
iclk  in  1  clock
irst  in  1  asynchronous, active-high reset
ireq_valid  in  1  memory-stage load or store present
ireq_we  in  1  1 = store, 0 = load
iaddr  in  MP_ADDR_WIDTH  byte address
isize  in  2  00 byte, 01 half, 10 word, 11 reserved
iwr_data  in  MP_DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
ord_data  out  MP_DATA_WIDTH  full read word, unshifted
ord_valid  out  1  ord_data valid this cycle (loads only)
ostall  out  1  hold memory stage and upstream stages
oerr_misaligned  out  1  one-cycle pulse on a misaligned or reserved-size request

Behaviour:
- Word index = iaddr[MP_DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0; any access with isize=11.
  - No write is performed and ord_data=0.
  - oerr_misaligned is asserted in the cycle the response would be valid.
- Store lane mapping, little-endian:
  - byte k goes to bits [8k+7:8k];
  - half goes to [15:0] when addr[1]=0, [31:16] when addr[1]=1.
- Store lane mapping, big-endian:
  - byte k goes to bits [31-8k:24-8k];
  - half goes to [31:16] when addr[1]=0, [15:0] when addr[1]=1.
- Unselected lanes are preserved (per-byte write enables).
- Memory contents are not reset. All other state and outputs reset to 0; FSM resets to IDLE.
- MP_WAIT_CYCLES=0:
  - No FSM activity; ostall is always 0.
  - Loads: ord_data is a combinational read of the addressed word; ord_valid = ireq_valid & ~ireq_we.
  - Stores commit at the rising edge ending the request cycle.
  - A load in the cycle after a store to the same word returns the new data.
- MP_WAIT_CYCLES=W>=1: FSM with states IDLE, WAIT, RESP.
  - IDLE: ostall = ireq_valid. On an edge with ireq_valid=1, latch addr, data, we and size, load cnt=W-1, and go to WAIT.
  - WAIT: ostall=1.
    - If cnt=0: perform the access at this edge (store commits; load word is captured into the read register), then go to RESP.
    - Otherwise decrement cnt.
  - RESP: ostall=0. ord_valid=1 for loads. oerr_misaligned is asserted if the latched request was misaligned.
  - RESP always returns to IDLE and ignores ireq_valid. The request visible in RESP is the same held request and must not be re-accepted.
  - Total stall = W+1 cycles per request; the response arrives in the first unstalled cycle.
- ord_data holds its last captured value outside RESP. ord_valid and oerr_misaligned are 0 outside their defined cycles.
- Reset mid-operation (WAIT or RESP): a pending store is discarded and the FSM returns to IDLE.
- Request inputs are sampled only in IDLE. Changes during WAIT or RESP are ignored.

Test Plan:
- W=0, big-endian: store word 0x11223344 at 0x0, then load 0x0. Expect ord_data=0x11223344 and ord_valid=1 in the load cycle; ostall stays 0.
- W=0, big-endian: after the previous step, store byte 0xAA at 0x1, then load 0x0. Expect 0x11AA3344. With MP_ENDIANESS=0, the same sequence gives 0x1122AA44.
- W=0, little-endian: store half 0xBEEF at 0x6 over 0x00000000, then load 0x4. Expect 0xBEEF0000.
- W=2: load request held steady. Expect ostall=1 for 3 cycles, then one cycle with ostall=0, ord_valid=1 and correct data. The held request in the RESP cycle does not start a new access.
- Misaligned: word store at 0x2 over existing 0xCAFEF00D. Expect an oerr_misaligned pulse, memory still 0xCAFEF00D, and ord_data=0 on a misaligned load.
- W=3: assert irst during WAIT of a store to 0x8. Expect the FSM back in IDLE and ostall=0. A subsequent load from 0x8 returns the pre-store value.

Source files
------------

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the pipelined core: lane placement of store data,
// full-word read return, and optional wait-state insertion with stall.
module riscv_dmem_resp #(
    parameter int unsigned MP_DATA_WIDTH  = 32,
    parameter int unsigned MP_ADDR_WIDTH  = 32,
    parameter int unsigned MP_DEPTH_LOG2  = 10,
    parameter int unsigned MP_WAIT_CYCLES = 0,
    parameter int unsigned MP_ENDIANESS   = 1
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ireq_valid,
    input  logic                     ireq_we,
    input  logic [MP_ADDR_WIDTH-1:0] iaddr,
    input  logic [1:0]               isize,
    input  logic [MP_DATA_WIDTH-1:0] iwr_data,
    output logic [MP_DATA_WIDTH-1:0] ord_data,
    output logic                     ord_valid,
    output logic                     ostall,
    output logic                     oerr_misaligned
);

    localparam int unsigned LP_DEPTH = 1 << MP_DEPTH_LOG2;
    localparam int unsigned LP_LANES = MP_DATA_WIDTH / 8;
    localparam int unsigned LP_LOW_W = MP_DEPTH_LOG2 + 2;
    localparam logic        LP_BIG   = (MP_ENDIANESS != 0);

    logic [MP_DATA_WIDTH-1:0] mem [LP_DEPTH];

    // Request currently being decoded: live inputs or the latched copy
    logic [LP_LOW_W-1:0]      sel_addr;
    logic [1:0]               sel_size;
    logic [MP_DATA_WIDTH-1:0] sel_data;
    logic [MP_DEPTH_LOG2-1:0] sel_idx;
    logic                     sel_mis;
    logic [LP_LANES-1:0]      sel_be;
    logic [MP_DATA_WIDTH-1:0] sel_wdat;
    logic [1:0]               byte_lane;
    logic                     wr_en;

    // Address bits above the memory depth are dropped so accesses wrap
    logic unused_addr_hi;
    assign unused_addr_hi = ^iaddr[MP_ADDR_WIDTH-1:LP_LOW_W];

    assign sel_idx   = sel_addr[LP_LOW_W-1:2];
    // Big-endian reverses the byte lane: lane = 3 - addr[1:0]
    assign byte_lane = sel_addr[1:0] ^ {2{LP_BIG}};

    // Decode size/alignment into byte enables and lane-replicated store data
    always_comb begin
        sel_mis  = 1'b0;
        sel_be   = '0;
        sel_wdat = '0;
        case (sel_size)
            2'b00: begin
                sel_be   = LP_LANES'(1) << byte_lane;
                sel_wdat = {LP_LANES{sel_data[7:0]}};
            end
            2'b01: begin
                if (sel_addr[0]) begin
                    sel_mis = 1'b1;
                end else begin
                    sel_be   = (sel_addr[1] ^ LP_BIG) ? 4'b1100 : 4'b0011;
                    sel_wdat = {2{sel_data[15:0]}};
                end
            end
            2'b10: begin
                if (sel_addr[1:0] != 2'b00) begin
                    sel_mis = 1'b1;
                end else begin
                    sel_be   = '1;
                    sel_wdat = sel_data;
                end
            end
            default: sel_mis = 1'b1;
        endcase
    end

    // Word memory with per-byte write enables; contents are never reset
    always_ff @(posedge iclk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < LP_LANES; b++) begin
                if (sel_be[b]) begin
                    mem[sel_idx][8*b +: 8] <= sel_wdat[8*b +: 8];
                end
            end
        end
    end

    if (MP_WAIT_CYCLES == 0) begin : g_comb
        assign sel_addr        = iaddr[LP_LOW_W-1:0];
        assign sel_size        = isize;
        assign sel_data        = iwr_data;
        assign wr_en           = ireq_valid & ireq_we & ~sel_mis & ~irst;
        assign ord_valid       = ireq_valid & ~ireq_we;
        assign oerr_misaligned = ireq_valid & sel_mis;
        assign ostall          = 1'b0;
        assign ord_data        = (ireq_valid & sel_mis) ? '0 : mem[sel_idx];
    end else begin : g_fsm
        localparam int unsigned LP_CNT_W =
            (MP_WAIT_CYCLES > 1) ? $clog2(MP_WAIT_CYCLES) : 1;

        typedef enum logic [1:0] {
            S_IDLE = 2'd0,
            S_WAIT = 2'd1,
            S_RESP = 2'd2
        } state_t;

        state_t                   state_q, state_d;
        logic [LP_CNT_W-1:0]      cnt_q, cnt_d;
        logic [LP_LOW_W-1:0]      addr_q;
        logic [1:0]               size_q;
        logic [MP_DATA_WIDTH-1:0] data_q;
        logic [MP_DATA_WIDTH-1:0] rd_q;
        logic                     we_q;
        logic                     latch_en;
        logic                     capture_en;

        assign sel_addr = addr_q;
        assign sel_size = size_q;
        assign sel_data = data_q;
        assign ord_data = rd_q;

        // State, wait counter, held request and read register
        always_ff @(posedge iclk or posedge irst) begin
            if (irst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                addr_q  <= '0;
                size_q  <= '0;
                data_q  <= '0;
                we_q    <= 1'b0;
                rd_q    <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (latch_en) begin
                    addr_q <= iaddr[LP_LOW_W-1:0];
                    size_q <= isize;
                    data_q <= iwr_data;
                    we_q   <= ireq_we;
                end
                if (capture_en) begin
                    rd_q <= sel_mis ? '0 : mem[sel_idx];
                end
            end
        end

        // Next state, access strobes and handshake outputs
        always_comb begin
            state_d         = state_q;
            cnt_d           = cnt_q;
            latch_en        = 1'b0;
            capture_en      = 1'b0;
            wr_en           = 1'b0;
            ostall          = 1'b0;
            ord_valid       = 1'b0;
            oerr_misaligned = 1'b0;
            case (state_q)
                S_IDLE: begin
                    ostall = ireq_valid;
                    if (ireq_valid) begin
                        latch_en = 1'b1;
                        cnt_d    = LP_CNT_W'(MP_WAIT_CYCLES - 1);
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    ostall = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_RESP;
                        if (we_q) begin
                            wr_en = ~sel_mis & ~irst;
                        end else begin
                            capture_en = 1'b1;
                        end
                    end else begin
                        cnt_d = LP_CNT_W'(cnt_q - 1'b1);
                    end
                end
                S_RESP: begin
                    ord_valid       = ~we_q;
                    oerr_misaligned = sel_mis;
                    state_d         = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
